// File: rtl/fetch_bpredict.sv
// Fetch-stage predecoder and branch predictor: RV32 control-flow predecode,
// return address stack, and static or bimodal conditional-branch prediction.
module fetch_bpredict #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4,
   parameter int BHT_IDX_W = 6,
   parameter int PRED_MODE = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fet_valid,
   input  logic                         fet_stall,
   input  logic                         flush,
   input  logic [XLEN-1:0]              fet_pc,
   input  logic [31:0]                  rv32_instr,
   input  logic [XLEN-1:0]              rs1_val,
   input  logic                         jalr_dep,
   input  logic [XLEN-1:0]              mepc,
   input  logic                         upd_valid,
   input  logic [XLEN-1:0]              upd_pc,
   input  logic                         upd_taken,
   output logic                         is_jal,
   output logic                         is_jalr,
   output logic                         is_bxx,
   output logic                         is_mret,
   output logic                         pred_redirect,
   output logic                         pred_taken,
   output logic [XLEN-1:0]              pred_target,
   output logic                         ras_hit,
   output logic                         jalr_stall,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BHT_N = 1 << BHT_IDX_W;

   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [31:0] MRET_WORD = 32'h3020_0073;

   // ---------------------------------------------------------------------
   // Predecode
   // ---------------------------------------------------------------------
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [XLEN-1:0] j_imm;
   logic [XLEN-1:0] b_imm;
   logic [XLEN-1:0] i_imm;
   logic [XLEN-1:0] link_addr;
   logic            rd_link;
   logic            rs1_link;

   assign opcode = rv32_instr[6:0];
   assign rd     = rv32_instr[11:7];
   assign rs1    = rv32_instr[19:15];

   assign j_imm = {{(XLEN-21){rv32_instr[31]}}, rv32_instr[31], rv32_instr[19:12],
                   rv32_instr[20], rv32_instr[30:21], 1'b0};
   assign b_imm = {{(XLEN-13){rv32_instr[31]}}, rv32_instr[31], rv32_instr[7],
                   rv32_instr[30:25], rv32_instr[11:8], 1'b0};
   assign i_imm = {{(XLEN-12){rv32_instr[31]}}, rv32_instr[31:20]};

   assign link_addr = fet_pc + XLEN'(4);

   assign is_jal  = fet_valid & (opcode == OP_JAL);
   assign is_jalr = fet_valid & (opcode == OP_JALR);
   assign is_bxx  = fet_valid & (opcode == OP_BRANCH);
   assign is_mret = fet_valid & (rv32_instr == MRET_WORD);

   assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
   assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

   // A link rs1 always pops: either a plain return, rd==rs1, or a
   // coroutine swap (rd!=rs1), the last two of which also push.
   logic push;
   logic pop;
   assign push = (is_jal | is_jalr) & rd_link;
   assign pop  = is_jalr & rs1_link;

   // ---------------------------------------------------------------------
   // Return address stack
   // ---------------------------------------------------------------------
   logic [XLEN-1:0]  ras_q [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [PTR_W-1:0] top_ptr;
   logic [XLEN-1:0]  ras_top;
   logic             ras_we;
   logic [PTR_W-1:0] ras_waddr;
   logic             ras_empty;
   logic             fire;

   assign top_ptr   = ptr_q - PTR_W'(1);
   assign ras_top   = ras_q[top_ptr];
   assign ras_empty = (cnt_q == '0);

   assign ras_hit    = pop & ~ras_empty;
   assign jalr_stall = is_jalr & ~ras_hit & jalr_dep;
   assign fire       = fet_valid & ~fet_stall & ~jalr_stall & ~flush;
   assign ras_count  = cnt_q;

   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path leaves it holding a value and a latch is never inferred.
   always_comb begin
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      ras_we    = 1'b0;
      ras_waddr = ptr_q;
      if (flush) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (fire) begin
         if (push && pop && !ras_empty) begin
            ras_we    = 1'b1;
            ras_waddr = top_ptr;
         end else if (push) begin
            ras_we    = 1'b1;
            ras_waddr = ptr_q;
            ptr_d     = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (pop && !ras_empty) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // NOTE: stack entries carry no reset; cnt_q alone decides which entries
   // are meaningful, so clearing the storage would only cost flops.
   always_ff @(posedge clk) begin
      if (ras_we && !rst) begin
         ras_q[ras_waddr] <= link_addr;
      end
   end

   // ---------------------------------------------------------------------
   // Bimodal branch history table
   // ---------------------------------------------------------------------
   logic [1:0]           bht_q [BHT_N];
   logic [BHT_IDX_W-1:0] upd_idx;
   logic [1:0]           upd_cur;
   logic [1:0]           upd_nxt;

   assign upd_idx = upd_pc[BHT_IDX_W+1:2];
   assign upd_cur = bht_q[upd_idx];

   always_comb begin
      upd_nxt = upd_cur;
      if (upd_taken && upd_cur != 2'b11) begin
         upd_nxt = upd_cur + 2'b01;
      end else if (!upd_taken && upd_cur != 2'b00) begin
         upd_nxt = upd_cur - 2'b01;
      end
   end

   // Counters reset to weakly not-taken; training ignores stall and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_N; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         bht_q[upd_idx] <= upd_nxt;
      end
   end

   logic unused_upd_pc;
   assign unused_upd_pc = ^{upd_pc[XLEN-1:BHT_IDX_W+2], upd_pc[1:0]};

   // ---------------------------------------------------------------------
   // Direction and target selection
   // ---------------------------------------------------------------------
   logic dir_taken;

   generate
      if (PRED_MODE == 0) begin : g_static
         assign dir_taken = rv32_instr[31];
      end else begin : g_bimodal
         logic [BHT_IDX_W-1:0] fet_idx;
         assign fet_idx   = fet_pc[BHT_IDX_W+1:2];
         assign dir_taken = bht_q[fet_idx][1];
      end
   endgenerate

   assign pred_taken = is_bxx & dir_taken;

   logic [XLEN-1:0] jalr_target;
   assign jalr_target = ras_hit ? (ras_top & ~XLEN'(1))
                                : ((rs1_val + i_imm) & ~XLEN'(1));

   always_comb begin
      pred_target = '0;
      if (fet_valid) begin
         if (is_jal) begin
            pred_target = fet_pc + j_imm;
         end else if (is_jalr) begin
            pred_target = jalr_target;
         end else if (pred_taken) begin
            pred_target = fet_pc + b_imm;
         end else if (is_mret) begin
            pred_target = mepc;
         end else begin
            pred_target = link_addr;
         end
      end
   end

   assign pred_redirect = fet_valid & ~jalr_stall &
                          (is_jal | is_jalr | is_mret | pred_taken);

endmodule

// File: tb/tb_fetch_bpredict.sv
// Directed bench for fetch_bpredict: a bimodal instance and a static instance
// share all inputs; expected values are hand-computed per vector.
module tb_fetch_bpredict;

   localparam int XLEN = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              fet_valid;
   logic              fet_stall;
   logic              flush;
   logic [XLEN-1:0]   fet_pc;
   logic [31:0]       rv32_instr;
   logic [XLEN-1:0]   rs1_val;
   logic              jalr_dep;
   logic [XLEN-1:0]   mepc;
   logic              upd_valid;
   logic [XLEN-1:0]   upd_pc;
   logic              upd_taken;

   logic              m_is_jal, m_is_jalr, m_is_bxx, m_is_mret;
   logic              m_redirect, m_taken, m_ras_hit, m_jalr_stall;
   logic [XLEN-1:0]   m_target;
   logic [2:0]        m_ras_count;

   logic              s_is_jal, s_is_jalr, s_is_bxx, s_is_mret;
   logic              s_redirect, s_taken, s_ras_hit, s_jalr_stall;
   logic [XLEN-1:0]   s_target;
   logic [2:0]        s_ras_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_bpredict #(.XLEN(XLEN), .RAS_DEPTH(4), .BHT_IDX_W(6), .PRED_MODE(1)) dut (
      .clk(clk), .rst(rst), .fet_valid(fet_valid), .fet_stall(fet_stall), .flush(flush),
      .fet_pc(fet_pc), .rv32_instr(rv32_instr), .rs1_val(rs1_val), .jalr_dep(jalr_dep),
      .mepc(mepc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .is_jal(m_is_jal), .is_jalr(m_is_jalr), .is_bxx(m_is_bxx), .is_mret(m_is_mret),
      .pred_redirect(m_redirect), .pred_taken(m_taken), .pred_target(m_target),
      .ras_hit(m_ras_hit), .jalr_stall(m_jalr_stall), .ras_count(m_ras_count)
   );

   fetch_bpredict #(.XLEN(XLEN), .RAS_DEPTH(4), .BHT_IDX_W(6), .PRED_MODE(0)) dut_s (
      .clk(clk), .rst(rst), .fet_valid(fet_valid), .fet_stall(fet_stall), .flush(flush),
      .fet_pc(fet_pc), .rv32_instr(rv32_instr), .rs1_val(rs1_val), .jalr_dep(jalr_dep),
      .mepc(mepc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .is_jal(s_is_jal), .is_jalr(s_is_jalr), .is_bxx(s_is_bxx), .is_mret(s_is_mret),
      .pred_redirect(s_redirect), .pred_taken(s_taken), .pred_target(s_target),
      .ras_hit(s_ras_hit), .jalr_stall(s_jalr_stall), .ras_count(s_ras_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b1100111};
   endfunction

   function automatic logic [31:0] enc_bxx(input logic [12:0] imm);
      return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
      fet_valid  = 1'b1;
      fet_pc     = pc;
      rv32_instr = instr;
      #1;
   endtask

   logic [31:0] ret_exp [4] = '{32'h54, 32'h44, 32'h34, 32'h24};

   initial begin
      rst = 1'b1; fet_valid = 1'b0; fet_stall = 1'b0; flush = 1'b0;
      fet_pc = '0; rv32_instr = '0; rs1_val = '0; jalr_dep = 1'b0;
      mepc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      #1;
      tick();
      rst = 1'b0;
      #1;
      check("reset_count", m_ras_count, 0);
      check("reset_redirect", m_redirect, 0);
      check("reset_target", m_target, 0);

      // Bimodal: first read sees weakly not-taken while training in the same cycle.
      upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
      drive(32'h100, enc_bxx(13'h0020));
      check("bxx_flag", m_is_bxx, 1);
      check("bxx_nt_taken", m_taken, 0);
      check("bxx_nt_redirect", m_redirect, 0);
      check("bxx_nt_target", m_target, 32'h104);
      check("bxx_static_pos", s_taken, 0);
      tick();
      check("bxx_t1_taken", m_taken, 1);
      tick();
      upd_valid = 1'b0;
      #1;
      check("bxx_t2_taken", m_taken, 1);
      check("bxx_t2_target", m_target, 32'h120);
      check("bxx_t2_redirect", m_redirect, 1);
      // Saturate high, then two not-taken must land on weakly not-taken.
      upd_valid = 1'b1; upd_taken = 1'b1;
      tick();
      upd_taken = 1'b0;
      tick();
      tick();
      upd_valid = 1'b0;
      #1;
      check("bht_sat_hi", m_taken, 0);

      fet_valid = 1'b0; rv32_instr = enc_jal(5'd1, 21'h200);
      #1;
      check("idle_is_jal", m_is_jal, 0);
      check("idle_target", m_target, 0);
      check("idle_redirect", m_redirect, 0);

      // Call then return through the RAS, then return on empty RAS.
      drive(32'h200, enc_jal(5'd1, 21'h000200));
      check("jal_flag", m_is_jal, 1);
      check("jal_target", m_target, 32'h400);
      check("jal_redirect", m_redirect, 1);
      tick();
      check("call_count", m_ras_count, 1);
      drive(32'h400, enc_jalr(5'd0, 5'd1, 12'h000));
      check("ret_hit", m_ras_hit, 1);
      check("ret_target", m_target, 32'h204);
      check("ret_stall", m_jalr_stall, 0);
      tick();
      check("ret_count", m_ras_count, 0);
      rs1_val = 32'h555;
      drive(32'h404, enc_jalr(5'd0, 5'd1, 12'h000));
      check("empty_ret_hit", m_ras_hit, 0);
      check("empty_ret_target", m_target, 32'h554);
      tick();
      check("empty_ret_count", m_ras_count, 0);

      // Overflow: five calls into a four-deep stack.
      for (int i = 0; i < 5; i++) begin
         drive(32'(32'h10 * (i + 1)), enc_jal(5'd1, 21'h000100));
         tick();
      end
      check("ovf_count", m_ras_count, 4);
      for (int i = 0; i < 4; i++) begin
         drive(32'h1000, enc_jalr(5'd0, 5'd1, 12'h000));
         check("ovf_ret_hit", m_ras_hit, 1);
         check($sformatf("ovf_ret_target%0d", i), m_target, ret_exp[i]);
         tick();
      end
      rs1_val = 32'h777;
      drive(32'h1000, enc_jalr(5'd0, 5'd1, 12'h000));
      check("ovf_ret5_hit", m_ras_hit, 0);
      check("ovf_ret5_target", m_target, 32'h776);
      tick();
      check("ovf_final_count", m_ras_count, 0);

      // Dependent jalr stalls and blocks RAS updates.
      drive(32'h600, enc_jal(5'd1, 21'h000100));
      tick();
      rs1_val = 32'h1000; jalr_dep = 1'b1;
      drive(32'h700, enc_jalr(5'd0, 5'd6, 12'h008));
      check("dep_stall", m_jalr_stall, 1);
      check("dep_redirect", m_redirect, 0);
      tick();
      check("dep_count", m_ras_count, 1);
      jalr_dep = 1'b0;
      #1;
      check("dep_clear_stall", m_jalr_stall, 0);
      check("dep_clear_target", m_target, 32'h1008);
      check("dep_clear_redirect", m_redirect, 1);
      tick();
      jalr_dep = 1'b1;
      drive(32'h710, enc_jalr(5'd1, 5'd6, 12'h008));
      tick();
      check("dep_push_blocked", m_ras_count, 1);
      jalr_dep = 1'b0;
      tick();
      check("dep_push_done", m_ras_count, 2);

      // Stall holds the RAS; flush clears it.
      fet_stall = 1'b1;
      drive(32'h720, enc_jal(5'd1, 21'h000100));
      tick();
      check("stall_count", m_ras_count, 2);
      fet_stall = 1'b0; flush = 1'b1;
      tick();
      check("flush_count", m_ras_count, 0);
      flush = 1'b0;
      mepc = 32'h8000_0040;
      drive(32'h740, 32'h3020_0073);
      check("mret_flag", m_is_mret, 1);
      check("mret_target", m_target, 32'h8000_0040);
      check("mret_redirect", m_redirect, 1);
      tick();

      // Coroutine swap on empty stack, swap on non-empty, then return.
      rs1_val = 32'h900;
      drive(32'h800, enc_jalr(5'd5, 5'd1, 12'h000));
      check("swap_empty_hit", m_ras_hit, 0);
      check("swap_empty_target", m_target, 32'h900);
      tick();
      check("swap_empty_count", m_ras_count, 1);
      drive(32'h900, enc_jalr(5'd1, 5'd5, 12'h000));
      check("swap_hit", m_ras_hit, 1);
      check("swap_target", m_target, 32'h804);
      tick();
      check("swap_count", m_ras_count, 1);
      drive(32'hA00, enc_jalr(5'd0, 5'd1, 12'h000));
      check("swap_ret_target", m_target, 32'h904);
      tick();
      check("swap_ret_count", m_ras_count, 0);

      // Low saturation at 0x300, then static vs bimodal on a backward branch.
      fet_valid = 1'b0;
      upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b0;
      tick();
      tick();
      tick();
      upd_taken = 1'b1;
      tick();
      upd_valid = 1'b0;
      drive(32'h300, enc_bxx(13'h1FF0));
      check("static_taken", s_taken, 1);
      check("static_target", s_target, 32'h2F0);
      check("static_redirect", s_redirect, 1);
      check("bht_sat_lo", m_taken, 0);
      check("bimodal_target", m_target, 32'h304);
      tick();

      // Reset mid-operation beats a push and a BHT update.
      drive(32'hB00, enc_jal(5'd1, 21'h000100));
      tick();
      check("pre_rst_count", m_ras_count, 1);
      rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
      tick();
      rst = 1'b0; upd_valid = 1'b0;
      drive(32'h100, enc_bxx(13'h0020));
      check("rst_mid_count", m_ras_count, 0);
      check("rst_mid_bht", m_taken, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_bpredict.md
Name: fetch_bpredict

Overview:
- Parametrised fetch-stage predecoder and branch predictor; next generation of the fetch mini-decoder.
- Sits between the instruction fetch buffer and the PC-select mux. Predecodes the fetched RV32 instruction combinationally and produces a redirect decision and target.
- Adds three things the mini-decoder lacks: a return address stack (RAS), a bimodal 2-bit branch history table (BHT) trained by the branch unit, and a selectable static/dynamic prediction mode.

Parameters:
- XLEN, 32, datapath/PC width.
- RAS_DEPTH, 4, RAS entries; power of 2, 2..16.
- BHT_IDX_W, 6, BHT index width (2^BHT_IDX_W counters).
- PRED_MODE, 1, conditional-branch predictor: 0 = static (taken iff offset negative); 1 = bimodal BHT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fet_valid  in  1  rv32_instr/fet_pc are valid this cycle.
- fet_stall  in  1  fetch held; no state update.
- flush  in  1  pipeline redirect from execute; clears RAS.
- fet_pc  in  XLEN  PC of rv32_instr.
- rv32_instr  in  32  fetched instruction.
- rs1_val  in  XLEN  forwarded rs1 value, used for jalr.
- jalr_dep  in  1  rs1 of jalr has an in-flight write.
- mepc  in  XLEN  mret target.
- upd_valid  in  1  BHT training strobe from branch unit.
- upd_pc  in  XLEN  PC of resolved branch.
- upd_taken  in  1  resolved direction.
- is_jal, is_jalr, is_bxx, is_mret  out  1 each  predecode flags, gated by fet_valid.
- pred_redirect  out  1  fetch must redirect to pred_target.
- pred_taken  out  1  conditional branch predicted taken.
- pred_target  out  XLEN  predicted next PC.
- ras_hit  out  1  jalr target taken from RAS.
- jalr_stall  out  1  fetch must hold.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries (debug/verification).

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. On reset: RAS pointer and ras_count = 0; all BHT counters = 2'b01 (weakly not-taken).
- All outputs are combinational from inputs and state; no output register. With fet_valid=0 every output except ras_count is 0.
- Predecode:
  - is_jal: opcode 1101111.
  - is_jalr: opcode 1100111.
  - is_bxx: opcode 1100011.
  - is_mret: full instruction == 32'h30200073.
- Immediates:
  - J and B immediates are sign-extended to XLEN with bit0 = 0.
  - I immediate (jalr) is sign-extended 12-bit.
  - All additions are modulo 2^XLEN.
- Link registers: x1 and x5.
  - push = is_jal|is_jalr with rd∈{x1,x5}.
  - pop = is_jalr with rs1∈{x1,x5}, and (rd∉{x1,x5} or rd==rs1).
  - is_jalr with rd∈link, rs1∈link and rd!=rs1: pop then push.
- Fire: fire = fet_valid & ~fet_stall & ~jalr_stall & ~flush. RAS changes only on fire.
- RAS:
  - Circular buffer. Push writes fet_pc+4 at top and increments the pointer; ras_count saturates at RAS_DEPTH (overflow overwrites the oldest entry).
  - Pop decrements the pointer and ras_count. Pop when empty: no change.
  - Pop+push in the same fire: top entry is replaced with fet_pc+4; count unchanged. Empty case: count becomes 1.
  - flush=1: ras_count = 0 and pointer = 0 next cycle; overrides any fire.
- jalr prediction:
  - ras_hit = pop & ras_count!=0; target = top entry & ~1.
  - Otherwise target = (rs1_val + imm) & ~1 and jalr_stall = jalr_dep.
  - jalr_stall is 0 whenever ras_hit=1.
- Conditional branch:
  - PRED_MODE=0: pred_taken = rv32_instr[31].
  - PRED_MODE=1: pred_taken = BHT[fet_pc[BHT_IDX_W+1:2]][1].
- pred_target:
  - jal: fet_pc+J-imm.
  - bxx taken: fet_pc+B-imm.
  - bxx not taken: fet_pc+4.
  - mret: mepc.
  - Otherwise: fet_pc+4.
- pred_redirect = fet_valid & ~jalr_stall & (is_jal | is_jalr | is_mret | is_bxx&pred_taken).
- BHT training:
  - On upd_valid, counter at upd_pc[BHT_IDX_W+1:2] increments if upd_taken, else decrements; saturating at 0 and 3.
  - Training is independent of fet_stall/flush.
  - A same-cycle read of the same index sees the old value (no bypass).
  - With PRED_MODE=0 the BHT is still present, but its training has no effect on outputs.
- Reset asserted mid-operation wins over all other updates that cycle.

Test Plan:
- Reset, then fetch bxx at fet_pc=0x100, offset +0x20, PRED_MODE=1 -> pred_taken=0, pred_redirect=0, pred_target=0x104. Then two upd_valid taken at upd_pc=0x100, refetch -> pred_taken=1, target=0x120, redirect=1.
- jal x1 at 0x200 (fire), then jalr x0,0(x1) at 0x400 -> ras_hit=1, pred_target=0x204, ras_count 1→0. Second return with empty RAS and rs1_val=0x555 -> ras_hit=0, target=0x554.
- RAS_DEPTH=4: five calls at 0x10,0x20,0x30,0x40,0x50 -> ras_count=4. Five returns -> targets 0x54,0x44,0x34,0x24, then ras_hit=0.
- jalr x0,8(x6) with jalr_dep=1, rs1_val=0x1000 -> jalr_stall=1, pred_redirect=0, no RAS change. jalr_dep drops -> target 0x1008, redirect=1.
- Call with fet_stall=1 -> ras_count unchanged. Call with flush=1 -> ras_count=0. mret with mepc=0x8000_0040 -> is_mret=1, target=0x8000_0040.
- PRED_MODE=0: bxx with negative offset at 0x300, offset -0x10 -> pred_taken=1, target=0x2F0, regardless of BHT training.
